// File: rtl/div_cache_unit_if.sv
// Request/response bus of the memoising divider: operand handshake, flush, result handshake.
interface div_cache_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] in_op1;
  logic [WIDTH-1:0] in_op2;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quo;
  logic [WIDTH-1:0] out_rem;
  logic             out_hit;
  logic             busy;

  // Requester / consumer side
  modport master (
    output in_valid, in_signed, in_op1, in_op2, flush, out_ready,
    input  in_ready, out_valid, out_quo, out_rem, out_hit, busy
  );

  // Divider side
  modport slave (
    input  in_valid, in_signed, in_op1, in_op2, flush, out_ready,
    output in_ready, out_valid, out_quo, out_rem, out_hit, busy
  );
endinterface

// File: rtl/div_cache_unit.sv
// Iterative restoring divider (signed/unsigned) with a small FIFO-replaced result cache.
// Cache hits, divide-by-zero and signed overflow answer in one cycle; other divisions
// take WIDTH restoring steps plus a sign-fix cycle.
module div_cache_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CACHE_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  div_cache_unit_if.slave  bus
);

  localparam int unsigned PTR_W = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CACHE_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  typedef struct packed {
    logic             sgn;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
  } entry_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] dvd, dvd_n;       // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs, dvs_n;       // divisor magnitude
  logic [WIDTH-1:0] prem, prem_n;     // partial remainder
  logic [WIDTH-1:0] op1_q, op1_n;
  logic [WIDTH-1:0] op2_q, op2_n;
  logic             sgn_q, sgn_n;
  logic [WIDTH-1:0] quo_q, quo_n;
  logic [WIDTH-1:0] rem_q, rem_n;
  logic             hit_q, hit_n;
  logic             valid_q, valid_n;
  logic             ready_q, busy_q;
  logic             wr_en;

  logic [CACHE_DEPTH-1:0] cvalid;
  entry_t                 centry [CACHE_DEPTH];
  logic [PTR_W-1:0]       ptr;

  logic             hit;
  logic [PTR_W-1:0] hit_idx;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] fix_quo, fix_rem;
  logic [WIDTH-1:0] abs1, abs2;
  entry_t           wr_entry;

  assign bus.in_ready  = ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = valid_q;
  assign bus.out_quo   = quo_q;
  assign bus.out_rem   = rem_q;
  assign bus.out_hit   = hit_q;

  // Cache lookup; lowest matching index wins, a same-cycle flush hides every entry
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = CACHE_DEPTH - 1; i >= 0; i--) begin
      if (cvalid[i] && centry[i].op1 == bus.in_op1 && centry[i].op2 == bus.in_op2 &&
          centry[i].sgn == bus.in_signed) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
    if (bus.flush) hit = 1'b0;
  end

  // Datapath helpers: one restoring step, sign fix-up, operand magnitudes
  always_comb begin
    shifted  = {prem, dvd[WIDTH-1]};
    ge       = shifted >= {1'b0, dvs};
    step_rem = ge ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
    fix_quo  = (sgn_q && (op1_q[WIDTH-1] ^ op2_q[WIDTH-1])) ? WIDTH'(-dvd) : dvd;
    fix_rem  = (sgn_q && op1_q[WIDTH-1]) ? WIDTH'(-prem) : prem;
    abs1     = (bus.in_signed && bus.in_op1[WIDTH-1]) ? WIDTH'(-bus.in_op1) : bus.in_op1;
    abs2     = (bus.in_signed && bus.in_op2[WIDTH-1]) ? WIDTH'(-bus.in_op2) : bus.in_op2;
    wr_entry = '{sgn: sgn_q, op1: op1_q, op2: op2_q, quo: fix_quo, rem: fix_rem};
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dvd_n   = dvd;
    dvs_n   = dvs;
    prem_n  = prem;
    op1_n   = op1_q;
    op2_n   = op2_q;
    sgn_n   = sgn_q;
    quo_n   = quo_q;
    rem_n   = rem_q;
    hit_n   = hit_q;
    valid_n = valid_q;
    wr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (hit) begin
            quo_n   = centry[hit_idx].quo;
            rem_n   = centry[hit_idx].rem;
            hit_n   = 1'b1;
            valid_n = 1'b1;
            state_n = DONE;
          end else if (bus.in_op2 == '0) begin
            quo_n   = '1;
            rem_n   = bus.in_op1;
            hit_n   = 1'b1;
            valid_n = 1'b1;
            state_n = DONE;
          end else if (bus.in_signed && bus.in_op1 == MOST_NEG && bus.in_op2 == '1) begin
            quo_n   = bus.in_op1;
            rem_n   = '0;
            hit_n   = 1'b1;
            valid_n = 1'b1;
            state_n = DONE;
          end else begin
            op1_n   = bus.in_op1;
            op2_n   = bus.in_op2;
            sgn_n   = bus.in_signed;
            dvd_n   = abs1;
            dvs_n   = abs2;
            prem_n  = '0;
            cnt_n   = CNT_W'(WIDTH - 1);
            state_n = CALC;
          end
        end
      end
      CALC: begin
        dvd_n  = {dvd[WIDTH-2:0], ge};
        prem_n = step_rem;
        cnt_n  = cnt - CNT_W'(1);
        if (cnt == '0) state_n = FIX;
      end
      FIX: begin
        quo_n   = fix_quo;
        rem_n   = fix_rem;
        hit_n   = 1'b0;
        valid_n = 1'b1;
        wr_en   = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      prem    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      sgn_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      hit_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      dvd     <= dvd_n;
      dvs     <= dvs_n;
      prem    <= prem_n;
      op1_q   <= op1_n;
      op2_q   <= op2_n;
      sgn_q   <= sgn_n;
      quo_q   <= quo_n;
      rem_q   <= rem_n;
      hit_q   <= hit_n;
      valid_q <= valid_n;
      ready_q <= (state_n == IDLE);
      busy_q  <= (state_n != IDLE);
    end
  end

  // Cache valid bits and FIFO pointer; a FIX write survives a simultaneous flush
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cvalid <= '0;
      ptr    <= '0;
    end else begin
      if (bus.flush) begin
        cvalid <= '0;
        ptr    <= '0;
      end
      if (wr_en) begin
        cvalid[ptr] <= 1'b1;
        if (!bus.flush) ptr <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
      end
    end
  end

  // Cache payload storage
  always_ff @(posedge clk) begin
    if (rstn && wr_en) centry[ptr] <= wr_entry;
  end

endmodule
